// File: rtl/scie_pipelined_fir.sv
// scie_pipelined_fir: SCIE-style custom-instruction unit holding a complex FIR filter.
//
// The instructions are decoded from io_insn[6:0] and act only while io_valid is high:
//   LOADC (7'b0001011) writes {io_rs1_real, io_rs1_imag} into coef[io_rs2].
//                      Indices >= NTAPS are ignored.
//   PUSH  (7'b0101011) shifts the delay line and puts rs1 into x[0].
//                      The oldest sample is dropped.
//   READ  (7'b1011011) registers sum_k coef[k]*x[k] into io_rd_real/io_rd_imag.
//                      The sum uses the state as it stands before the edge.
//
// Ports:
//   clock, reset           rising-edge clock; synchronous active-high reset
//   io_valid, io_insn      instruction strobe and instruction word
//   io_rs1_real/imag       signed complex operand (coefficient or sample)
//   io_rs2                 unsigned tap index for LOADC
//   io_rd_real/imag        registered result of the last READ
//
// Optional build macro SCIE_FIR_SATURATE_EN clamps each result component to the
// DATA_W signed range. Without it, each result component wraps to DATA_W bits.
module scie_pipelined_fir #(
   parameter int unsigned NTAPS  = 5,
   parameter int unsigned DATA_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     io_valid,
   input  logic [31:0]              io_insn,
   input  logic signed [DATA_W-1:0] io_rs1_real,
   input  logic signed [DATA_W-1:0] io_rs1_imag,
   input  logic [31:0]              io_rs2,
   output logic signed [DATA_W-1:0] io_rd_real,
   output logic signed [DATA_W-1:0] io_rd_imag
);

   localparam logic [6:0] OP_LOADC = 7'b0001011;
   localparam logic [6:0] OP_PUSH  = 7'b0101011;
   localparam logic [6:0] OP_READ  = 7'b1011011;

   localparam int unsigned IDX_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
   localparam int unsigned PROD_W = 2 * DATA_W;
   // One bit for the add/sub of two products, plus growth for summing NTAPS terms.
   localparam int unsigned ACC_W  = PROD_W + 2 + IDX_W;

   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic signed [DATA_W-1:0] coef_re_q [NTAPS];
   logic signed [DATA_W-1:0] coef_im_q [NTAPS];
   logic signed [DATA_W-1:0] x_re_q    [NTAPS];
   logic signed [DATA_W-1:0] x_im_q    [NTAPS];
   logic signed [DATA_W-1:0] rd_re_q, rd_im_q;

   logic signed [PROD_W-1:0] p_rr [NTAPS];
   logic signed [PROD_W-1:0] p_ii [NTAPS];
   logic signed [PROD_W-1:0] p_ri [NTAPS];
   logic signed [PROD_W-1:0] p_ir [NTAPS];
   logic signed [ACC_W-1:0]  acc_re, acc_im;
   logic signed [DATA_W-1:0] res_re, res_im;

   // Full-precision partial products per tap.
   always_comb begin
      for (int k = 0; k < NTAPS; k++) begin
         p_rr[k] = coef_re_q[k] * x_re_q[k];
         p_ii[k] = coef_im_q[k] * x_im_q[k];
         p_ri[k] = coef_re_q[k] * x_im_q[k];
         p_ir[k] = coef_im_q[k] * x_re_q[k];
      end
   end

   always_comb begin
      acc_re = '0;
      acc_im = '0;
      for (int k = 0; k < NTAPS; k++) begin
         acc_re = acc_re + ACC_W'(p_rr[k]) - ACC_W'(p_ii[k]);
         acc_im = acc_im + ACC_W'(p_ri[k]) + ACC_W'(p_ir[k]);
      end
   end

`ifdef SCIE_FIR_SATURATE_EN
   always_comb begin
      if (acc_re > SAT_MAX)      res_re = SAT_MAX[DATA_W-1:0];
      else if (acc_re < SAT_MIN) res_re = SAT_MIN[DATA_W-1:0];
      else                       res_re = acc_re[DATA_W-1:0];
      if (acc_im > SAT_MAX)      res_im = SAT_MAX[DATA_W-1:0];
      else if (acc_im < SAT_MIN) res_im = SAT_MIN[DATA_W-1:0];
      else                       res_im = acc_im[DATA_W-1:0];
   end
`else
   logic unused_sat;
   assign unused_sat = ^{SAT_MAX, SAT_MIN};
   assign res_re = acc_re[DATA_W-1:0];
   assign res_im = acc_im[DATA_W-1:0];
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int k = 0; k < NTAPS; k++) begin
            coef_re_q[k] <= '0;
            coef_im_q[k] <= '0;
            x_re_q[k]    <= '0;
            x_im_q[k]    <= '0;
         end
         rd_re_q <= '0;
         rd_im_q <= '0;
      end else if (io_valid) begin
         case (io_insn[6:0])
            OP_LOADC: begin
               if (io_rs2 < 32'(NTAPS)) begin
                  coef_re_q[io_rs2[IDX_W-1:0]] <= io_rs1_real;
                  coef_im_q[io_rs2[IDX_W-1:0]] <= io_rs1_imag;
               end
            end
            OP_PUSH: begin
               for (int k = NTAPS - 1; k > 0; k--) begin
                  x_re_q[k] <= x_re_q[k-1];
                  x_im_q[k] <= x_im_q[k-1];
               end
               x_re_q[0] <= io_rs1_real;
               x_im_q[0] <= io_rs1_imag;
            end
            OP_READ: begin
               rd_re_q <= res_re;
               rd_im_q <= res_im;
            end
            default: ;
         endcase
      end
   end

   assign io_rd_real = rd_re_q;
   assign io_rd_imag = rd_im_q;

endmodule

// File: tb/tb_scie_pipelined_fir.sv
// tb_scie_pipelined_fir: the main instruction stream is driven from a table.
// A reference model feeds a scoreboard queue with the expected result of every READ.
// Fixed golden values are checked where they are known.
// The reset and wrap/saturate corner cases are driven as hand-written sequences.
module tb_scie_pipelined_fir;

   localparam logic [6:0] OP_L = 7'b0001011;
   localparam logic [6:0] OP_P = 7'b0101011;
   localparam logic [6:0] OP_R = 7'b1011011;
   localparam logic [6:0] OP_N = 7'b0000000;

   logic               clock = 1'b0;
   logic               reset;
   logic               io_valid;
   logic [31:0]        io_insn;
   logic signed [15:0] io_rs1_real, io_rs1_imag;
   logic [31:0]        io_rs2;
   logic signed [15:0] io_rd_real, io_rd_imag;

   scie_pipelined_fir dut (
      .clock      (clock),
      .reset      (reset),
      .io_valid   (io_valid),
      .io_insn    (io_insn),
      .io_rs1_real(io_rs1_real),
      .io_rs1_imag(io_rs1_imag),
      .io_rs2     (io_rs2),
      .io_rd_real (io_rd_real),
      .io_rd_imag (io_rd_imag)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0] op;
      bit         valid;
      int         re;
      int         im;
      int         rs2;
      bit         chk;
      int         exp_re;
      int         exp_im;
   } vec_t;

   vec_t        tbl[$];
   logic [31:0] sb_q[$];
   int          n_checks = 0;
   int          n_pass = 0;

   // Reference model state
   int          m_cre[5], m_cim[5], m_xre[5], m_xim[5];
   logic [15:0] m_rd_re, m_rd_im;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, want %0d", name, $signed(act), $signed(exp));
   endtask

   task automatic model_clear();
      for (int k = 0; k < 5; k++) begin
         m_cre[k] = 0; m_cim[k] = 0; m_xre[k] = 0; m_xim[k] = 0;
      end
      m_rd_re = '0;
      m_rd_im = '0;
   endtask

   function automatic logic [15:0] fold(input longint s);
`ifdef SCIE_FIR_SATURATE_EN
      if (s > 32767) return 16'h7fff;
      if (s < -32768) return 16'h8000;
`endif
      return s[15:0];
   endfunction

   function automatic logic [31:0] model_read();
      longint sr = 0;
      longint si = 0;
      for (int k = 0; k < 5; k++) begin
         sr += longint'(m_cre[k]) * m_xre[k] - longint'(m_cim[k]) * m_xim[k];
         si += longint'(m_cre[k]) * m_xim[k] + longint'(m_cim[k]) * m_xre[k];
      end
      return {fold(sr), fold(si)};
   endfunction

   task automatic step(input vec_t v, input string name);
      logic [31:0] e;
      @(negedge clock);
      io_valid    = v.valid;
      io_insn     = $urandom();
      io_insn[6:0] = v.op;
      io_rs1_real = 16'(v.re);
      io_rs1_imag = 16'(v.im);
      io_rs2      = v.rs2;
      if (v.valid && v.op == OP_R) sb_q.push_back(model_read());
      @(posedge clock);
      #1;
      io_valid = 1'b0;
      if (v.valid && v.op == OP_L && v.rs2 >= 0 && v.rs2 < 5) begin
         m_cre[v.rs2] = 32'(16'(v.re) * 1);
         m_cre[v.rs2] = int'($signed(16'(v.re)));
         m_cim[v.rs2] = int'($signed(16'(v.im)));
      end else if (v.valid && v.op == OP_P) begin
         for (int k = 4; k > 0; k--) begin
            m_xre[k] = m_xre[k-1];
            m_xim[k] = m_xim[k-1];
         end
         m_xre[0] = int'($signed(16'(v.re)));
         m_xim[0] = int'($signed(16'(v.im)));
      end
      if (v.valid && v.op == OP_R) begin
         if (sb_q.size() == 0) begin
            check({name, "_sb_empty"}, 16'd1, 16'd0);
         end else begin
            e = sb_q.pop_front();
            m_rd_re = e[31:16];
            m_rd_im = e[15:0];
            check({name, "_re"}, io_rd_real, m_rd_re);
            check({name, "_im"}, io_rd_imag, m_rd_im);
         end
      end else begin
         check({name, "_hold_re"}, io_rd_real, m_rd_re);
         check({name, "_hold_im"}, io_rd_imag, m_rd_im);
      end
      if (v.chk) begin
         check({name, "_gold_re"}, io_rd_real, 16'(v.exp_re));
         check({name, "_gold_im"}, io_rd_imag, 16'(v.exp_im));
      end
   endtask

   task automatic do_reset(input logic [6:0] op);
      @(negedge clock);
      reset    = 1'b1;
      io_valid = 1'b1;
      io_insn  = {25'd0, op};
      io_rs1_real = 16'sd123;
      io_rs1_imag = 16'sd45;
      io_rs2   = 32'd0;
      @(posedge clock);
      #1;
      reset    = 1'b0;
      io_valid = 1'b0;
      model_clear();
      sb_q.delete();
   endtask

   initial begin
      int wrap_exp;
      reset = 1'b1; io_valid = 1'b0; io_insn = '0;
      io_rs1_real = '0; io_rs1_imag = '0; io_rs2 = '0;
      model_clear();
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      check("reset_re", io_rd_real, 16'd0);
      check("reset_im", io_rd_imag, 16'd0);

      // {op, valid, re, im, rs2, chk, exp_re, exp_im}
      tbl.push_back('{OP_L, 1, 2, 42, 0, 0, 0, 0});
      tbl.push_back('{OP_L, 1, -29, -21, 1, 0, 0, 0});
      tbl.push_back('{OP_L, 1, 13, 33, 2, 0, 0, 0});
      tbl.push_back('{OP_L, 1, -25, -46, 3, 0, 0, 0});
      tbl.push_back('{OP_L, 1, -49, -37, 4, 0, 0, 0});
      tbl.push_back('{OP_P, 1, 1, -12, 0, 0, 0, 0});
      tbl.push_back('{OP_N, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, 506, 18});
      tbl.push_back('{OP_P, 1, 40, 17, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, -915, 2041});
      tbl.push_back('{OP_P, 1, -15, 23, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, -1390, -2040});
      tbl.push_back('{OP_P, 1, 22, -6, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, 596, 2355});
      tbl.push_back('{OP_P, 1, 20, -44, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, -541, -1446});
      tbl.push_back('{OP_P, 1, -34, 29, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, -2204, -2064});
      tbl.push_back('{OP_P, 1, -32, 6, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, 3751, -2805});
      // Out-of-range tap index must leave coefficients alone.
      tbl.push_back('{OP_L, 1, 999, -999, 7, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, 3751, -2805});
      // io_valid low: nothing may change for any opcode.
      tbl.push_back('{OP_L, 0, 500, 500, 0, 0, 0, 0});
      tbl.push_back('{OP_P, 0, 77, 77, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 0, 0, 0, 0, 1, 3751, -2805});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 1, 3751, -2805});
      // Reload one tap, then a back-to-back PUSH and READ.
      tbl.push_back('{OP_L, 1, 300, -7, 2, 0, 0, 0});
      tbl.push_back('{OP_P, 1, 11, 5, 0, 0, 0, 0});
      tbl.push_back('{OP_R, 1, 0, 0, 0, 0, 0, 0});

      foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

      // A reset must win over an instruction issued in the same cycle.
      step('{OP_P, 1, 9, -3, 0, 0, 0, 0}, "pre_rst_push");
      do_reset(OP_R);
      check("midrst_re", io_rd_real, 16'd0);
      check("midrst_im", io_rd_imag, 16'd0);
      step('{OP_R, 1, 0, 0, 0, 1, 0, 0}, "post_rst_read");
      step('{OP_P, 1, 100, 100, 0, 0, 0, 0}, "post_rst_push");
      step('{OP_R, 1, 0, 0, 0, 1, 0, 0}, "post_rst_nocoef");

      // Full-scale sum: the real part overflows 16 bits.
`ifdef SCIE_FIR_SATURATE_EN
      wrap_exp = 32767;
`else
      wrap_exp = 5;
`endif
      do_reset(OP_N);
      for (int k = 0; k < 5; k++) step('{OP_L, 1, 32767, 0, k, 0, 0, 0}, "wrap_load");
      for (int k = 0; k < 5; k++) step('{OP_P, 1, 32767, 0, 0, 0, 0, 0}, "wrap_push");
      step('{OP_R, 1, 0, 0, 0, 1, wrap_exp, 0}, "wrap_read");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1);
   end

endmodule
